// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the BCD stopwatch: FSM states, BCD digit type
// and the four-digit decimal increment.
package stopwatch_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [3:0] digit_t;
  typedef digit_t [NUM_DIGITS-1:0] bcd4_t;

  localparam digit_t BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_t;

  // Ripple-carry decimal increment; MSB of the result is the 9999->0000 wrap.
  function automatic logic [16:0] bcd_inc(input bcd4_t v);
    bcd4_t r;
    logic  c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (c) begin
        if (v[i] >= BCD_MAX) begin
          r[i] = '0;
        end else begin
          r[i] = v[i] + 4'd1;
          c    = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button front end: synchronizer, stable-level debounce and a one-cycle
// press pulse on the debounced released->pressed transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   db_n;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          arm_cnt;
  logic                   armed;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= key_n;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // A key must be seen released for a full debounce window after reset before
  // presses are honoured, so a key held through reset stays silent until re-pressed.
  // This relies on DEBOUNCE_CYCLES exceeding SYNC_STAGES.
  always_ff @(posedge clk) begin
    if (rst) begin
      arm_cnt <= '0;
      armed   <= 1'b0;
    end else if (!armed) begin
      if (!sync_out) begin
        arm_cnt <= '0;
      end else if (arm_cnt == CNT_LAST) begin
        armed <= 1'b1;
      end else begin
        arm_cnt <= arm_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_n  <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_out == db_n) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db_n  <= sync_out;
        cnt   <= '0;
        press <= armed && !sync_out;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_stopwatch.sv
// Four-digit BCD stopwatch: start/pause and clear keys drive an IDLE/RUN/PAUSE
// FSM; the count advances on tick while running and flags the 9999 wrap.
module bcd_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        key_start_n,
  input  logic        key_clear_n,
  output logic [15:0] bcd,
  output logic        running,
  output logic        overflow
);

  logic [1:0] press_ev;
  logic       start_ev;
  logic       clear_ev;
  sw_state_t  state;
  bcd4_t      bcd_q;
  bcd4_t      inc_val;
  logic       inc_wrap;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_key [1:0] (
    .clk  (clk),
    .rst  (rst),
    .key_n({key_clear_n, key_start_n}),
    .press(press_ev)
  );

  assign start_ev = press_ev[0];
  assign clear_ev = press_ev[1];

  assign {inc_wrap, inc_val} = bcd_inc(bcd_q);
  assign bcd = bcd_q;

  // Counting keys off the registered state, so the tick in the cycle RUN is
  // left still counts and the one in the cycle RUN is entered does not.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      bcd_q    <= '0;
      running  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (state == ST_RUN && tick) begin
        bcd_q <= inc_val;
        if (inc_wrap) overflow <= 1'b1;
      end
      case (state)
        ST_RUN: begin
          if (start_ev) begin
            state   <= ST_PAUSE;
            running <= 1'b0;
          end
        end
        default: begin
          if (clear_ev) begin
            state    <= ST_IDLE;
            bcd_q    <= '0;
            overflow <= 1'b0;
            running  <= 1'b0;
          end else if (start_ev) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/bcd_stopwatch.md
BCD_STOPWATCH -- requirements
Module: bcd_stopwatch

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, the number of stable clk cycles needed to accept a key level (20 ms at 50 MHz).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops on each key input.
REQ-003 SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous active-high reset.
- tick  in  1  one-cycle count enable from the frequency divider, synchronous to clk.
- key_start_n  in  1  active-low push button, asynchronous; toggles run/pause.
- key_clear_n  in  1  active-low push button, asynchronous; clears the count.
- bcd  out  16  four BCD digits; [3:0] is the least significant digit; feeds the 7-segment decoders.
- running  out  1  high while in RUN.
- overflow  out  1  sticky flag, set on the 9999->0000 wrap.

Function
REQ-004 Each key SHALL pass through SYNC_STAGES flops, then a debounce counter; the debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-005 Any bounce SHALL restart the debounce counter.
REQ-006 A press event SHALL be a single-cycle pulse on the debounced released->pressed transition; release SHALL produce no event.
REQ-007 The FSM SHALL have the states IDLE, RUN and PAUSE.
REQ-008 A start event SHALL move IDLE->RUN, RUN->PAUSE and PAUSE->RUN.
REQ-009 A clear event in IDLE or PAUSE SHALL move to IDLE, zero bcd and clear overflow; a clear event in RUN SHALL be ignored.
REQ-010 When start and clear events occur in the same cycle:
- in RUN, start SHALL take effect (move to PAUSE);
- in IDLE or PAUSE, clear SHALL take effect and start SHALL be discarded.
REQ-011 bcd SHALL increment by one when the registered state is RUN and tick=1; it SHALL NOT increment in any other state.
REQ-012 A tick in the cycle a start event leaves RUN SHALL still count; a tick in the cycle a start event enters RUN SHALL NOT count.
REQ-013 Increment SHALL be decimal ripple: a digit at 9 SHALL go to 0 and carry into the next digit; digits SHALL never hold 10-15.
REQ-014 The increment from 9999 SHALL produce 0000, set overflow=1 and keep RUN.
REQ-015 overflow SHALL clear only on a clear event or rst.
REQ-016 bcd, running and overflow SHALL be registered outputs and SHALL update one cycle after the qualifying input cycle.
REQ-017 running SHALL equal (state==RUN).

Reset
REQ-018 rst SHALL force IDLE, bcd=16'h0000, running=0, overflow=0, debounced levels to released, and debounce counters and synchronizers to their released values.
REQ-019 rst asserted mid-RUN or mid-debounce SHALL abort the operation with no residual event after rst deasserts.
REQ-020 A key held pressed through reset SHALL generate a press event only after it is released and pressed again.

Structure
REQ-021 The state enum and the digit type (4-bit BCD) SHALL reside in package stopwatch_pkg, together with constant BCD_MAX=4'd9.
REQ-022 Synchronizer, debounce and edge detection SHALL be one sub-module, key_debounce, instantiated once per key; the FSM and the counter SHALL reside in bcd_stopwatch.

Verification (DEBOUNCE_CYCLES=4)
REQ-023 rst=1 for 2 cycles, then tick every 3 cycles with no keys pressed -> bcd=0000, running=0, overflow=0 throughout.
REQ-024 key_start_n low for 10 cycles, then 25 ticks -> running=1 after the debounce delay, bcd=0025 (hex 16'h0025); a second press -> PAUSE, and further ticks leave bcd=0025.
REQ-025 key_start_n toggling with 2-cycle glitches, then low for 3 cycles -> no event and state stays IDLE; low for 6 cycles -> exactly one event.
REQ-026 Preload to 9998 by ticks in RUN, then 2 ticks -> bcd=0000, overflow=1, running=1; clear pressed in RUN -> ignored; pause, then clear -> bcd=0000, overflow=0, IDLE.
REQ-027 Start and clear events in the same cycle:
- in PAUSE -> IDLE with bcd=0000;
- in RUN -> PAUSE with bcd unchanged (plus any same-cycle tick).
REQ-028 rst pulsed while in RUN at bcd=0137 -> next cycle bcd=0000 and IDLE; a key held across rst produces no event until re-pressed.
